// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard controller.
//   fwd_sel_t     : branch comparator operand select (register file / EX-MEM ALU result)
//   stall_cause_t : reported reason for the current stall
//   md_state_t    : mul/div occupancy tracker states
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01
    } fwd_sel_t;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_LOAD   = 2'b01,
        CAUSE_BRANCH = 2'b10,
        CAUSE_MD     = 2'b11
    } stall_cause_t;

    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/hazard_if.sv
// Bundle between the pipeline (master) and the hazard controller (slave).
//   pipeline -> controller : ID operand/instruction info, EX and MEM write-back info,
//                            stall counter clear
//   controller -> pipeline : stall / id_flush, comparator forward selects,
//                            stall cause, mul/div busy, stall counter
interface hazard_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_branch;
    logic              id_md_start;
    logic              id_md_read;
    logic              ex_regwrite;
    logic              ex_memread;
    logic [REG_AW-1:0] ex_rd;
    logic              mem_regwrite;
    logic              mem_memtoreg;
    logic [REG_AW-1:0] mem_rd;
    logic              stall_cnt_clr;

    logic              stall;
    logic              id_flush;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [1:0]        stall_cause;
    logic              md_busy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch,
               id_md_start, id_md_read, ex_regwrite, ex_memread, ex_rd,
               mem_regwrite, mem_memtoreg, mem_rd, stall_cnt_clr,
        input  stall, id_flush, fwd_a, fwd_b, stall_cause, md_busy, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch,
               id_md_start, id_md_read, ex_regwrite, ex_memread, ex_rd,
               mem_regwrite, mem_memtoreg, mem_rd, stall_cnt_clr,
        output stall, id_flush, fwd_a, fwd_b, stall_cause, md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_md_busy_tracker.sv
// Mul/div occupancy tracker: IDLE/BUSY FSM with a down-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   issue      : a mult/div is accepted this cycle
//   busy       : unit occupied; high for MD_LATENCY-1 cycles after an accepted issue
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue,
    output logic busy
);
    localparam logic [0:0] ST_IDLE = MD_IDLE;
    localparam logic [0:0] ST_BUSY = MD_BUSY;

    // A single-cycle unit is never occupied beyond its issue cycle.
    localparam bit CAN_BUSY = (MD_LATENCY > 1);
    localparam int CW       = (MD_LATENCY > 2) ? $clog2(MD_LATENCY - 1) : 1;
    localparam int LOAD_INT = (MD_LATENCY > 1) ? (MD_LATENCY - 2) : 0;
    localparam logic [CW-1:0] LOAD_VAL = LOAD_INT[CW-1:0];

    logic [0:0]    state_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (issue && CAN_BUSY) begin
                        state_reg <= ST_BUSY;
                        cnt_reg   <= LOAD_VAL;
                    end
                end
                default: begin
                    // Count 0 marks the last occupied cycle.
                    if (cnt_reg == '0) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy = (state_reg == ST_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection and ID-stage branch forwarding for a 5-stage MIPS pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : hazard_if slave port (pipeline status in, stall/forward/status out)
// Detects load-use, branch-in-ID and mul/div-busy hazards, selects comparator
// forwarding from EX/MEM, reports the stall cause and counts stalled cycles.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    hazard_if.slave  bus
);
    // Register 0 is hard-wired, so it never creates a dependency.
    function automatic logic reg_hit(input logic use_op,
                                     input logic [REG_AW-1:0] src,
                                     input logic [REG_AW-1:0] rd);
        return use_op && (src == rd) && (rd != '0);
    endfunction

    logic         md_busy;
    logic         load_haz;
    logic         br_haz;
    logic         md_haz;
    logic         stall;
    logic         md_issue;
    stall_cause_t cause;
    fwd_sel_t     fwd_a_sel;
    fwd_sel_t     fwd_b_sel;
    logic [CNT_W-1:0] cnt_reg;

    always_comb begin
        load_haz = bus.ex_memread &&
                   (reg_hit(bus.id_use_rs, bus.id_rs, bus.ex_rd) ||
                    reg_hit(bus.id_use_rt, bus.id_rt, bus.ex_rd));

        // Branch compares in ID: an EX result is not ready yet, and a load in
        // MEM has no data until WB; only a MEM ALU result can be forwarded.
        br_haz = bus.id_branch &&
                 ((bus.ex_regwrite &&
                   (reg_hit(bus.id_use_rs, bus.id_rs, bus.ex_rd) ||
                    reg_hit(bus.id_use_rt, bus.id_rt, bus.ex_rd))) ||
                  (bus.mem_regwrite && bus.mem_memtoreg &&
                   (reg_hit(bus.id_use_rs, bus.id_rs, bus.mem_rd) ||
                    reg_hit(bus.id_use_rt, bus.id_rt, bus.mem_rd))));

        md_haz = md_busy && (bus.id_md_start || bus.id_md_read);

        stall = bus.id_valid && (load_haz || br_haz || md_haz);

        cause = CAUSE_NONE;
        if (stall) begin
            if (load_haz)    cause = CAUSE_LOAD;
            else if (br_haz) cause = CAUSE_BRANCH;
            else             cause = CAUSE_MD;
        end

        fwd_a_sel = FWD_RF;
        fwd_b_sel = FWD_RF;
        if (!stall && bus.id_valid && bus.id_branch &&
            bus.mem_regwrite && !bus.mem_memtoreg) begin
            if (reg_hit(bus.id_use_rs, bus.id_rs, bus.mem_rd)) fwd_a_sel = FWD_MEM;
            if (reg_hit(bus.id_use_rt, bus.id_rt, bus.mem_rd)) fwd_b_sel = FWD_MEM;
        end
    end

    // A stalled mult/div is held in ID and retried, so it must not start the unit.
    assign md_issue = bus.id_valid && bus.id_md_start && !stall;

    md_busy_tracker #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_busy_tracker (
        .clk   (clk),
        .rst_n (rst_n),
        .issue (md_issue),
        .busy  (md_busy)
    );

    // Saturating stall counter; clear wins over a coincident stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (bus.stall_cnt_clr) begin
            cnt_reg <= '0;
        end else if (stall && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign bus.stall       = stall;
    assign bus.id_flush    = stall;
    assign bus.fwd_a       = fwd_a_sel;
    assign bus.fwd_b       = fwd_b_sel;
    assign bus.stall_cause = cause;
    assign bus.md_busy     = md_busy;
    assign bus.stall_cnt   = cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (MD_LATENCY=4/CNT_W=16 and
// MD_LATENCY=2/CNT_W=2) see identical stimulus. A driver pushes the reference
// model's expectation per instance per cycle; a negedge monitor pops and compares.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_if #(.REG_AW(5), .CNT_W(16)) ifa ();
    hazard_if #(.REG_AW(5), .CNT_W(2))  ifb ();

    hazard_ctrl #(.REG_AW(5), .MD_LATENCY(4), .CNT_W(16)) u_dut_a (
        .clk (clk), .rst_n (rst_n), .bus (ifa.slave));
    hazard_ctrl #(.REG_AW(5), .MD_LATENCY(2), .CNT_W(2)) u_dut_b (
        .clk (clk), .rst_n (rst_n), .bus (ifb.slave));

    typedef struct {
        bit rst_n, id_valid, use_rs, use_rt, branch, md_start, md_read;
        bit ex_regwrite, ex_memread, mem_regwrite, mem_memtoreg, clr;
        int rs, rt, ex_rd, mem_rd;
    } stim_t;

    typedef struct {
        int inst;
        bit stall;
        int fa, fb, cause;
        bit busy;
        int cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: remaining occupied cycles and stalled-cycle count.
    int   busy_left[2];
    int   cnt_m[2];
    int   lat[2]  = '{4, 2};
    int   cmax[2] = '{65535, 3};

    task automatic check(input string name, input int inst, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s inst=%0d got=%0d expected=%0d t=%0t", name, inst, act, exp, $time);
    endtask

    function automatic bit hit(input bit use_op, input int src, input int rd);
        return use_op && (src == rd) && (rd != 0);
    endfunction

    function automatic exp_t predict(input stim_t s, input int k);
        exp_t e;
        bit ld, br, md, any_rs_rt_ex, any_rs_rt_mem;
        any_rs_rt_ex  = hit(s.use_rs, s.rs, s.ex_rd)  || hit(s.use_rt, s.rt, s.ex_rd);
        any_rs_rt_mem = hit(s.use_rs, s.rs, s.mem_rd) || hit(s.use_rt, s.rt, s.mem_rd);
        ld = s.ex_memread && any_rs_rt_ex;
        br = s.branch && ((s.ex_regwrite && any_rs_rt_ex) ||
                          (s.mem_regwrite && s.mem_memtoreg && any_rs_rt_mem));
        md = (busy_left[k] > 0) && (s.md_start || s.md_read);
        e.inst  = k;
        e.stall = s.id_valid && (ld || br || md);
        e.cause = !e.stall ? 0 : (ld ? 1 : (br ? 2 : 3));
        e.fa = (!e.stall && s.id_valid && s.branch && s.mem_regwrite && !s.mem_memtoreg &&
                hit(s.use_rs, s.rs, s.mem_rd)) ? 1 : 0;
        e.fb = (!e.stall && s.id_valid && s.branch && s.mem_regwrite && !s.mem_memtoreg &&
                hit(s.use_rt, s.rt, s.mem_rd)) ? 1 : 0;
        e.busy = busy_left[k] > 0;
        e.cnt  = cnt_m[k];
        return e;
    endfunction

    task automatic apply(input stim_t s);
        rst_n = s.rst_n;
        ifa.id_valid = s.id_valid;      ifb.id_valid = s.id_valid;
        ifa.id_rs = 5'(s.rs);           ifb.id_rs = 5'(s.rs);
        ifa.id_rt = 5'(s.rt);           ifb.id_rt = 5'(s.rt);
        ifa.id_use_rs = s.use_rs;       ifb.id_use_rs = s.use_rs;
        ifa.id_use_rt = s.use_rt;       ifb.id_use_rt = s.use_rt;
        ifa.id_branch = s.branch;       ifb.id_branch = s.branch;
        ifa.id_md_start = s.md_start;   ifb.id_md_start = s.md_start;
        ifa.id_md_read = s.md_read;     ifb.id_md_read = s.md_read;
        ifa.ex_regwrite = s.ex_regwrite; ifb.ex_regwrite = s.ex_regwrite;
        ifa.ex_memread = s.ex_memread;  ifb.ex_memread = s.ex_memread;
        ifa.ex_rd = 5'(s.ex_rd);        ifb.ex_rd = 5'(s.ex_rd);
        ifa.mem_regwrite = s.mem_regwrite; ifb.mem_regwrite = s.mem_regwrite;
        ifa.mem_memtoreg = s.mem_memtoreg; ifb.mem_memtoreg = s.mem_memtoreg;
        ifa.mem_rd = 5'(s.mem_rd);      ifb.mem_rd = 5'(s.mem_rd);
        ifa.stall_cnt_clr = s.clr;      ifb.stall_cnt_clr = s.clr;
    endtask

    // Drive one cycle: push expectations for the current state, then advance the model.
    task automatic step(input stim_t s);
        exp_t e;
        apply(s);
        for (int k = 0; k < 2; k++) begin
            if (!s.rst_n) begin
                busy_left[k] = 0;
                cnt_m[k]     = 0;
            end
            e = predict(s, k);
            q.push_back(e);
            if (s.rst_n) begin
                if (s.clr)                            cnt_m[k] = 0;
                else if (e.stall && cnt_m[k] < cmax[k]) cnt_m[k]++;
                busy_left[k] = (busy_left[k] > 0) ? busy_left[k] - 1 : 0;
                if (s.id_valid && s.md_start && !e.stall && lat[k] > 1)
                    busy_left[k] = lat[k] - 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: 0};
        s.rst_n = 1'b1;
        return s;
    endfunction

    // Monitor: compares every pushed expectation against the instance it names.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            if (e.inst == 0) begin
                check("stall",    0, int'(ifa.stall),       int'(e.stall));
                check("id_flush", 0, int'(ifa.id_flush),    int'(e.stall));
                check("fwd_a",    0, int'(ifa.fwd_a),       e.fa);
                check("fwd_b",    0, int'(ifa.fwd_b),       e.fb);
                check("cause",    0, int'(ifa.stall_cause), e.cause);
                check("md_busy",  0, int'(ifa.md_busy),     int'(e.busy));
                check("cnt",      0, int'(ifa.stall_cnt),   e.cnt);
            end else begin
                check("stall",    1, int'(ifb.stall),       int'(e.stall));
                check("id_flush", 1, int'(ifb.id_flush),    int'(e.stall));
                check("fwd_a",    1, int'(ifb.fwd_a),       e.fa);
                check("fwd_b",    1, int'(ifb.fwd_b),       e.fb);
                check("cause",    1, int'(ifb.stall_cause), e.cause);
                check("md_busy",  1, int'(ifb.md_busy),     int'(e.busy));
                check("cnt",      1, int'(ifb.stall_cnt),   e.cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        busy_left = '{0, 0};
        cnt_m     = '{0, 0};
        s = idle_stim();
        s.rst_n = 1'b0;
        apply(s);
        @(posedge clk);
        #1;
        step(s);                                  // reset state

        // Load-use on rs, then register 0 (no hazard).
        s = idle_stim(); s.id_valid = 1; s.ex_memread = 1; s.ex_rd = 8; s.rs = 8; s.use_rs = 1;
        step(s);
        s.ex_rd = 0; s.rs = 0;
        step(s);
        // Branch vs EX writer on rt.
        s = idle_stim(); s.id_valid = 1; s.branch = 1; s.ex_regwrite = 1; s.ex_rd = 9;
        s.rt = 9; s.use_rt = 1;
        step(s);
        // Branch with MEM ALU result on both operands: forward both.
        s = idle_stim(); s.id_valid = 1; s.branch = 1; s.mem_regwrite = 1; s.mem_rd = 9;
        s.rs = 9; s.rt = 9; s.use_rs = 1; s.use_rt = 1;
        step(s);
        // Branch vs load in MEM: stall, no forward.
        s = idle_stim(); s.id_valid = 1; s.branch = 1; s.mem_regwrite = 1; s.mem_memtoreg = 1;
        s.mem_rd = 5; s.rs = 5; s.use_rs = 1;
        step(s);
        // Unused rt matching a load in EX: no stall.
        s = idle_stim(); s.id_valid = 1; s.ex_memread = 1; s.ex_rd = 7; s.rt = 7; s.use_rt = 0;
        s.rs = 3; s.use_rs = 1;
        step(s);

        // Mult at cycle 0, mflo at cycles 2 and 4.
        s = idle_stim(); s.id_valid = 1; s.md_start = 1;   step(s);
        s = idle_stim();                                   step(s);
        s = idle_stim(); s.id_valid = 1; s.md_read = 1;    step(s);
        s = idle_stim();                                   step(s);
        s = idle_stim(); s.id_valid = 1; s.md_read = 1;    step(s);

        // Counter: 3 stalls, clear with stall, then 5 stalls (saturates the 2-bit one).
        s = idle_stim(); s.id_valid = 1; s.ex_memread = 1; s.ex_rd = 4; s.rs = 4; s.use_rs = 1;
        for (int i = 0; i < 3; i++) step(s);
        s.clr = 1; step(s);
        s.clr = 0;
        for (int i = 0; i < 5; i++) step(s);
        s = idle_stim(); step(s);

        // Reset pulse during BUSY, then a fresh mult issues without stalling.
        s = idle_stim(); s.id_valid = 1; s.md_start = 1;   step(s);
        s = idle_stim();                                   step(s);
        s.rst_n = 0;                                       step(s);
        s = idle_stim(); s.id_valid = 1; s.md_start = 1;   step(s);
        s = idle_stim();                                   step(s);

        // Randomised traffic with a small register range to provoke matches.
        for (int i = 0; i < 1500; i++) begin
            s.rst_n        = ($urandom_range(0, 199) != 0);
            s.id_valid     = ($urandom_range(0, 7) != 0);
            s.use_rs       = $urandom_range(0, 1);
            s.use_rt       = $urandom_range(0, 1);
            s.branch       = ($urandom_range(0, 2) == 0);
            s.md_start     = ($urandom_range(0, 3) == 0);
            s.md_read      = ($urandom_range(0, 3) == 0);
            s.ex_regwrite  = $urandom_range(0, 1);
            s.ex_memread   = ($urandom_range(0, 3) == 0);
            s.mem_regwrite = $urandom_range(0, 1);
            s.mem_memtoreg = $urandom_range(0, 1);
            s.clr          = ($urandom_range(0, 15) == 0);
            s.rs           = $urandom_range(0, 3);
            s.rt           = $urandom_range(0, 3);
            s.ex_rd        = $urandom_range(0, 3);
            s.mem_rd       = $urandom_range(0, 3);
            step(s);
        end

        @(negedge clk);
        #1;
        check("sb_drain", 0, q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
